// File: rtl/aes_uart_core.sv
// -----------------------------------------------------------------------------
// aes_uart_core
// Serial link self-test core. A rising edge on start sends the fixed 14-byte
// MESSAGE through an 8N1 UART transmitter. The transmitter output is looped
// back into an 8N1 UART receiver. The receiver shifts each accepted byte into
// data_out. valid is raised once all 14 bytes have arrived.
//
// Ports
//   clk      in   1    system clock, rising edge
//   reset    in   1    asynchronous active-high reset
//   start    in   1    level input; a rising edge launches one transfer
//   valid    out  1    data_out holds a complete received message
//   data_out out  112  received message, first byte in [111:104]
// -----------------------------------------------------------------------------
module aes_uart_core #(
   parameter int           CLKS_PER_BIT = 868,
   parameter logic [111:0] MESSAGE      = 112'h4145535F6F7665725F5541525421
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         valid,
   output logic [111:0] data_out
);

   localparam int            CW        = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   // The receiver enters START one cycle after the line falls, so checking
   // at CLKS_PER_BIT/2-1 puts every later sample near the middle of its bit.
   localparam logic [CW-1:0] HALF_CHK  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]    NUM_BYTES = 4'd14;

   // ---------------------------------------------------------------- message
   // Padded to 16 entries so the 4-bit index never addresses past the array.
   logic [7:0] msg_byte [16];
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_msg
         if (gi < 14) begin : g_used
            assign msg_byte[gi] = MESSAGE[111 - 8*gi -: 8];
         end else begin : g_pad
            assign msg_byte[gi] = 8'h00;
         end
      end
   endgenerate

   // ---------------------------------------------------------- start detect
   logic start_q;
   logic start_edge;
   assign start_edge = start & ~start_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) start_q <= 1'b0;
      else       start_q <= start;
   end

   // ------------------------------------------------------------ controller
   typedef enum logic [1:0] {C_IDLE, C_LOAD, C_SEND, C_WAIT_RX} ctrl_t;
   ctrl_t      ctrl_q, ctrl_d;
   logic [3:0] idx_q, idx_d;
   logic       valid_q, valid_d;
   logic       tx_start;
   logic       rx_clear;
   logic       tx_done_q;
   logic [3:0] rx_bytes_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q  <= C_IDLE;
         idx_q   <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      ctrl_d   = ctrl_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      tx_start = 1'b0;
      rx_clear = 1'b0;
      case (ctrl_q)
         C_IDLE: begin
            // Edges seen outside IDLE are simply not acted upon.
            if (start_edge) begin
               ctrl_d   = C_LOAD;
               valid_d  = 1'b0;
               idx_d    = 4'd0;
               rx_clear = 1'b1;
            end
         end
         C_LOAD: begin
            tx_start = 1'b1;
            ctrl_d   = C_SEND;
         end
         C_SEND: begin
            if (tx_done_q) begin
               idx_d  = idx_q + 4'd1;
               ctrl_d = (idx_q == NUM_BYTES - 4'd1) ? C_WAIT_RX : C_LOAD;
            end
         end
         C_WAIT_RX: begin
            if (rx_bytes_q == NUM_BYTES) begin
               valid_d = 1'b1;
               ctrl_d  = C_IDLE;
            end
         end
         default: ctrl_d = C_IDLE;
      endcase
   end

   // ---------------------------------------------------------- transmitter
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_t;
   uart_t         tx_state_q, tx_state_d;
   logic [CW-1:0] tx_clk_q, tx_clk_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          tx_line_q, tx_line_d;
   logic          tx_done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= S_IDLE;
         tx_clk_q   <= '0;
         tx_bit_q   <= 3'd0;
         tx_sh_q    <= 8'h00;
         tx_line_q  <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_clk_q   <= tx_clk_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_line_q  <= tx_line_d;
         tx_done_q  <= tx_done_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_clk_d   = tx_clk_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_line_d  = tx_line_q;
      tx_done_d  = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            tx_line_d = 1'b1;
            if (tx_start) begin
               tx_sh_d    = msg_byte[idx_q];
               tx_line_d  = 1'b0;
               tx_clk_d   = '0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_clk_q == BIT_LAST) begin
               tx_clk_d   = '0;
               tx_bit_d   = 3'd0;
               tx_line_d  = tx_sh_q[0];
               tx_state_d = S_DATA;
            end else begin
               tx_clk_d = tx_clk_q + 1'b1;
            end
         end
         S_DATA: begin
            if (tx_clk_q == BIT_LAST) begin
               tx_clk_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_line_d  = 1'b1;
                  tx_state_d = S_STOP;
               end else begin
                  tx_bit_d  = tx_bit_q + 3'd1;
                  tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                  tx_line_d = tx_sh_q[1];
               end
            end else begin
               tx_clk_d = tx_clk_q + 1'b1;
            end
         end
         S_STOP: begin
            if (tx_clk_q == BIT_LAST) begin
               tx_clk_d   = '0;
               tx_done_d  = 1'b1;
               tx_state_d = S_IDLE;
            end else begin
               tx_clk_d = tx_clk_q + 1'b1;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- receiver
   uart_t          rx_state_q, rx_state_d;
   logic [CW-1:0]  rx_clk_q, rx_clk_d;
   logic [2:0]     rx_bit_q, rx_bit_d;
   logic [7:0]     rx_sh_q, rx_sh_d;
   logic [3:0]     rx_bytes_d;
   logic [111:0]   data_q, data_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q <= S_IDLE;
         rx_clk_q   <= '0;
         rx_bit_q   <= 3'd0;
         rx_sh_q    <= 8'h00;
         rx_bytes_q <= 4'd0;
         data_q     <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_clk_q   <= rx_clk_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_bytes_q <= rx_bytes_d;
         data_q     <= data_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_clk_d   = rx_clk_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_bytes_d = rx_bytes_q;
      data_d     = data_q;
      case (rx_state_q)
         S_IDLE: begin
            if (!tx_line_q) begin
               rx_clk_d   = '0;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_clk_q == HALF_CHK) begin
               rx_clk_d   = '0;
               rx_bit_d   = 3'd0;
               // A line back at 1 here was a glitch, not a start bit.
               rx_state_d = tx_line_q ? S_IDLE : S_DATA;
            end else begin
               rx_clk_d = rx_clk_q + 1'b1;
            end
         end
         S_DATA: begin
            if (rx_clk_q == BIT_LAST) begin
               rx_clk_d = '0;
               rx_sh_d  = {tx_line_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end else begin
               rx_clk_d = rx_clk_q + 1'b1;
            end
         end
         S_STOP: begin
            if (rx_clk_q == BIT_LAST) begin
               rx_clk_d   = '0;
               rx_state_d = S_IDLE;
               // Bytes with a bad stop bit are dropped without counting.
               if (tx_line_q) begin
                  data_d     = {data_q[103:0], rx_sh_q};
                  rx_bytes_d = rx_bytes_q + 4'd1;
               end
            end else begin
               rx_clk_d = rx_clk_q + 1'b1;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
      if (rx_clear) begin
         data_d     = '0;
         rx_bytes_d = 4'd0;
      end
   end

   assign valid    = valid_q;
   assign data_out = data_q;

endmodule

// File: tb/tb_aes_uart_core.sv
module tb_aes_uart_core;

   localparam int           CPB_A = 4;
   localparam int           CPB_B = 6;
   localparam logic [111:0] MSG_A = 112'h4145535F6F7665725F5541525421;
   localparam logic [111:0] MSG_B = 112'hFF;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         valid_a, valid_b;
   logic [111:0] data_a, data_b;

   always #5 clk = ~clk;

   aes_uart_core #(.CLKS_PER_BIT(CPB_A)) dut_a (
      .clk(clk), .reset(reset), .start(start), .valid(valid_a), .data_out(data_a));

   aes_uart_core #(.CLKS_PER_BIT(CPB_B), .MESSAGE(MSG_B)) dut_b (
      .clk(clk), .reset(reset), .start(start), .valid(valid_b), .data_out(data_b));

   int checks = 0;
   int errors = 0;
   logic [111:0] qa[$];
   logic [111:0] qb[$];
   int lat_a, lat_b;

   task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_expected();
      qa.push_back(MSG_A);
      qb.push_back(MSG_B);
   endtask

   // One transfer request; optionally drop start again after one cycle.
   task automatic launch(input bit pulse);
      @(negedge clk);
      start = 1'b1;
      push_expected();
      if (pulse) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   // Waits (bounded) for a valid rise on both instances; scoreboard compare.
   // off = negedges already elapsed since the start edge was registered.
   task automatic wait_done(input string tag, input int off, input bit chk_lat);
      int   n  = 0;
      bit   da = 1'b0;
      bit   db = 1'b0;
      logic pa = valid_a;
      logic pb = valid_b;
      logic [111:0] e;
      while (!(da && db) && n < 2000) begin
         @(negedge clk);
         n++;
         if (valid_a && !pa && !da) begin
            da = 1'b1;
            lat_a = n - 1 + off;
            chk({tag, "_sb_a"}, 112'(qa.size() != 0), 112'd1);
            if (qa.size() != 0) begin
               e = qa.pop_front();
               chk({tag, "_data_a"}, data_a, e);
            end
            $display("xfer %s A: latency=%0d data=%h", tag, lat_a, data_a);
         end
         if (valid_b && !pb && !db) begin
            db = 1'b1;
            lat_b = n - 1 + off;
            chk({tag, "_sb_b"}, 112'(qb.size() != 0), 112'd1);
            if (qb.size() != 0) begin
               e = qb.pop_front();
               chk({tag, "_data_b"}, data_b, e);
            end
            $display("xfer %s B: latency=%0d data=%h", tag, lat_b, data_b);
         end
         pa = valid_a;
         pb = valid_b;
      end
      chk({tag, "_done_a"}, 112'(da), 112'd1);
      chk({tag, "_done_b"}, 112'(db), 112'd1);
      if (chk_lat) begin
         chk({tag, "_lat_a"}, 112'(lat_a >= 139*CPB_A && lat_a <= 141*CPB_A + 32), 112'd1);
         chk({tag, "_lat_b"}, 112'(lat_b >= 139*CPB_B && lat_b <= 141*CPB_B + 32), 112'd1);
      end
   endtask

   task automatic hold_high(input string tag, input int ncyc);
      int drops = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (valid_a !== 1'b1 || valid_b !== 1'b1 || data_a !== MSG_A || data_b !== MSG_B)
            drops++;
      end
      chk(tag, 112'(drops), 112'd0);
   endtask

   initial begin
      int bad;
      reset = 1'b1;
      start = 1'b0;

      // Long reset: outputs must stay cleared throughout.
      bad = 0;
      repeat (3500) begin
         @(negedge clk);
         if (valid_a !== 1'b0 || valid_b !== 1'b0 || data_a !== '0 || data_b !== '0) bad++;
      end
      chk("reset_hold_bad", 112'(bad), 112'd0);
      chk("reset_valid_a", 112'(valid_a), 112'd0);
      chk("reset_data_a", data_a, 112'd0);
      chk("reset_data_b", data_b, 112'd0);

      // Release reset with start already high, hold start 1500+ cycles.
      reset = 1'b0;
      start = 1'b1;
      push_expected();
      wait_done("hold", 0, 1'b1);
      hold_high("hold_one_xfer", 1000);
      start = 1'b0;

      // New start edge while valid is high: outputs clear next cycle.
      @(negedge clk);
      start = 1'b1;
      push_expected();
      @(negedge clk);
      start = 1'b0;
      chk("restart_valid_a", 112'(valid_a), 112'd0);
      chk("restart_data_a", data_a, 112'd0);
      chk("restart_valid_b", 112'(valid_b), 112'd0);
      chk("restart_data_b", data_b, 112'd0);
      wait_done("restart", 1, 1'b1);
      hold_high("restart_hold", 1000);

      // Extra start edge in the middle of a transfer is ignored.
      launch(1'b1);
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("mid", 0, 1'b0);
      hold_high("mid_single", 300);
      chk("mid_sb_empty", 112'(qa.size() + qb.size()), 112'd0);

      // Reset during byte 7 of A, then re-issue start.
      launch(1'b1);
      repeat (290) @(negedge clk);
      chk("partial_nonzero", 112'(data_a != '0), 112'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_valid_a", 112'(valid_a), 112'd0);
      chk("midrst_data_a", data_a, 112'd0);
      chk("midrst_data_b", data_b, 112'd0);
      $display("xfer midrst: reset applied, partial message discarded");
      qa.delete();
      qb.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("idle_after_rst_data_a", data_a, 112'd0);
      chk("idle_after_rst_valid_b", 112'(valid_b), 112'd0);
      launch(1'b1);
      wait_done("after_rst", 1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
